// File: rtl/bool_pkg.sv
// bool_pkg: shared operation and FSM state types for the sequential boolean reducer
package bool_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_RSVD} op_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCUM, S_DONE} state_t;
endpackage

// File: rtl/bool_op2.sv
// bool_op2: shared two-operand bitwise boolean unit; reserved op passes a through
module bool_op2
  import bool_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  op_t                  op,
  output logic [BUS_WIDTH-1:0] y
);
  always_comb y = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : a;
endmodule

// File: rtl/bool_reduce_seq.sv
// bool_reduce_seq: folds NB_INS streamed operands through one shared boolean unit
module bool_reduce_seq
  import bool_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int NB_INS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  output logic                 busy,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data
);
  localparam int CNT_W = $clog2(NB_INS);
  state_t state, state_d;
  op_t op_q, op_d;
  logic [BUS_WIDTH-1:0] acc, acc_d, y;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic err_d, accept, last, launch;
  bool_op2 #(.BUS_WIDTH(BUS_WIDTH)) u_op (.a(acc), .b(in_data), .op(op_q), .y(y));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_AND;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      err   <= err_d;
    end
  always_comb begin
    state_d = state;
    op_d    = op_q;
    acc_d   = acc;
    cnt_d   = cnt;
    err_d   = 1'b0;
    accept  = in_valid && in_ready;
    last    = cnt == CNT_W'(NB_INS - 1);
    launch  = start && (state == S_IDLE || (state == S_DONE && out_ready));
    case (state)
      S_LOAD:
        if (accept) begin
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          state_d = S_ACCUM;
        end
      S_ACCUM:
        if (accept) begin
          acc_d   = y;
          cnt_d   = last ? cnt : cnt + CNT_W'(1);
          state_d = last ? S_DONE : S_ACCUM;
        end
      default: begin
        if (state == S_DONE && out_ready) state_d = S_IDLE;
        if (launch && op_t'(op) == OP_RSVD) err_d = 1'b1;
        else if (launch) begin
          state_d = S_LOAD;
          op_d    = op_t'(op);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end
  assign busy      = state != S_IDLE;
  assign in_ready  = state == S_LOAD || state == S_ACCUM;
  assign out_valid = state == S_DONE;
  assign out_data  = acc;
endmodule

// File: tb/tb_bool_reduce_seq.sv
// tb_bool_reduce_seq: directed and randomized checks against a fold-over-array reference
module tb_bool_reduce_seq;
  localparam int NB = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] in_data = 8'd0;
  logic busy, err, in_ready, out_valid;
  logic [7:0] out_data;
  int checks = 0, failures = 0, accepts = 0, last_lat = 0;
  logic [7:0] ops [NB];

  bool_reduce_seq #(.BUS_WIDTH(8), .NB_INS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (in_valid && in_ready) accepts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] d [NB]);
    logic [7:0] r;
    r = d[0];
    for (int i = 1; i < NB; i++)
      r = o == 2'd0 ? (r & d[i]) : o == 2'd1 ? (r | d[i]) : (r ^ d[i]);
    return r;
  endfunction

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
  endtask

  // leaves the DUT in DONE with the result checked; handshake is done by the caller
  task automatic do_job(input logic [1:0] o, input int gap_max, input int stall, input bit noise, input bit skip_start);
    logic [7:0] exp;
    int lat, a0;
    exp = model(o, ops);
    a0 = accepts;
    lat = 0;
    if (!skip_start) begin
      start = 1'b1; op = o; tick(); lat++; start = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        if (noise) begin start = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3)); end
        tick(); lat++; start = 1'b0;
        chk("gap_ready", in_ready, 1);
        chk("gap_err", err, 0);
      end
      in_valid = 1'b1; in_data = ops[i]; tick(); lat++; in_valid = 1'b0;
    end
    last_lat = lat;
    chk("accepts", accepts - a0, NB);
    chk("done_valid", out_valid, 1);
    chk("result", out_data, exp);
    repeat (stall) begin
      out_ready = 1'b0; tick();
      chk("stall_data", out_data, exp);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
  endtask

  task automatic finish_job();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_ready", in_ready, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b0; tick();
    // AND, no gaps, latency
    set_ops(8'hF3, 8'h3F, 8'h7E, 8'hFF);
    do_job(2'd0, 0, 0, 0, 0);
    chk("and_val", out_data, 8'h32);
    chk("and_latency", last_lat, NB + 1);
    finish_job();
    // OR with one idle cycle between operands
    set_ops(8'h01, 8'h02, 8'h04, 8'h08);
    do_job(2'd1, 1, 0, 0, 0);
    chk("or_val", out_data, 8'h0F);
    finish_job();
    // XOR with a 3-cycle output stall
    set_ops(8'hAA, 8'h0F, 8'hF0, 8'h11);
    do_job(2'd2, 0, 3, 0, 0);
    chk("xor_val", out_data, 8'h44);
    finish_job();
    // reserved op in IDLE
    start = 1'b1; op = 2'd3; tick(); start = 1'b0;
    chk("rsvd_err", err, 1);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_ready", in_ready, 0);
    tick();
    chk("rsvd_err_clr", err, 0);
    chk("rsvd_busy2", busy, 0);
    // back-to-back: start on the handshake cycle
    set_ops(8'h00, 8'hFF, 8'h12, 8'h34);
    do_job(2'd0, 0, 0, 0, 0);
    out_ready = 1'b1; start = 1'b1; op = 2'd1; tick(); out_ready = 1'b0; start = 1'b0;
    chk("b2b_ready", in_ready, 1);
    chk("b2b_valid", out_valid, 0);
    chk("b2b_clear", out_data, 0);
    set_ops(8'h10, 8'h20, 8'h40, 8'h80);
    do_job(2'd1, 0, 0, 0, 1);
    chk("b2b_val", out_data, 8'hF0);
    // reserved op on the handshake cycle: err and back to IDLE
    out_ready = 1'b1; start = 1'b1; op = 2'd3; tick(); out_ready = 1'b0; start = 1'b0;
    chk("done_rsvd_err", err, 1);
    chk("done_rsvd_busy", busy, 0);
    // asynchronous reset in ACCUM after two operands
    start = 1'b1; op = 2'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; tick(); in_data = 8'hC3; tick(); in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    tick(); rst = 1'b0; tick();
    set_ops(8'hFF, 8'h0F, 8'hFF, 8'hFF);
    do_job(2'd0, 0, 0, 0, 0);
    chk("post_rst_val", out_data, 8'h0F);
    finish_job();
    // randomized jobs with gaps, stalls and ignored start noise
    for (int j = 0; j < 25; j++) begin
      set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      do_job(2'($urandom_range(0, 2)), 2, $urandom_range(0, 3), 1, 0);
      finish_job();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bool_reduce_seq.md
# bool_reduce_seq

Sequential boolean reduction controller. It accepts NB_INS operand buses one at a time over a valid/ready stream and folds them through a single shared 2-operand boolean unit. It then presents the reduced bus on an output valid/ready stream. It sits beside the combinational parametrized reducers, trading area for latency when NB_INS is large or when operands arrive serially from a bus.

## Interface
- BUS_WIDTH, 8: width of every operand and of the result.
- NB_INS, 4: operands per job; legal values are 2 or more.
- CNT_W, derived localparam = $clog2(NB_INS): operand counter width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new job; sampled only in IDLE or in the DONE handshake cycle.
- op  in  2  operation, sampled with start: 00 AND, 01 OR, 10 XOR, 11 reserved.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when start is sampled with op=11.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_data  in  BUS_WIDTH  operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  BUS_WIDTH  result; driven from the accumulator register.

## Operation
- **States:**
  - IDLE: in_ready=0, out_valid=0.
  - LOAD: in_ready=1.
  - ACCUM: in_ready=1.
  - DONE: out_valid=1, in_ready=0.
- **IDLE:**
  - start with a legal op: latch op, acc<=0, cnt<=0, go to LOAD.
  - start with op=11: pulse err, stay in IDLE.
- **LOAD:** on in_valid&&in_ready: acc<=in_data, cnt<=1, go to ACCUM.
- **ACCUM:**
  - On accept: acc<=acc op in_data, cnt<=cnt+1.
  - If the accepted operand is index NB_INS-1, go to DONE.
  - Cycles with no accept hold all state.
- **DONE:**
  - out_data holds stable while out_ready=0.
  - On out_ready: go to IDLE.
  - If start with a legal op is also high in that cycle: go directly to LOAD, latch the new op, clear acc and cnt (back-to-back jobs).
  - If start with op=11 is high in that cycle: pulse err and go to IDLE.
- start outside IDLE and the DONE handshake cycle is ignored, and op is not re-sampled.
- Arithmetic is purely bitwise with no carries, so the result width equals BUS_WIDTH.
- The counter never wraps: the exit to DONE occurs at cnt=NB_INS-1 on accept.
- **Reset (including mid-job):** state=IDLE, acc=0, cnt=0, latched op=AND, busy=0, err=0, in_ready=0, out_valid=0, out_data=0. Partial results are discarded.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational paths from in_valid or out_ready to any output.
- start sampled at edge N puts in_ready=1 during cycle N+1.
- With in_valid held high, operands are accepted on NB_INS consecutive edges. out_valid rises the cycle after the last accept, so start-to-out_valid is NB_INS+1 cycles minimum.
- out_valid falls the cycle after the out_ready handshake edge.
- err is high for exactly the one cycle after the offending start edge.
- Throughput in back-to-back mode is one job per NB_INS+1 cycles.

## Structure
- **Package bool_pkg:**
  - typedef enum logic[1:0] op_t with OP_AND, OP_OR, OP_XOR, OP_RSVD.
  - typedef enum logic[1:0] state_t with S_IDLE, S_LOAD, S_ACCUM, S_DONE.
- **Sub-module bool_op2 (BUS_WIDTH):** combinational a, b, op -> y. It is the single shared operator, instanced once; OP_RSVD yields y=a.
- The top holds the FSM, the counter, the acc register and handshake decode.

## Test plan
- AND, BUS_WIDTH=8, NB_INS=4, operands F3,3F,7E,FF with no gaps -> out_data=32, out_valid high exactly 5 cycles after start.
- OR, operands 01,02,04,08 with one idle in_valid cycle between each -> out_data=0F, in_ready stays 1 through the gaps, accept count=4.
- XOR, operands AA,0F,F0,11, out_ready low 3 cycles -> out_data=44 stable and in_ready=0 throughout the stall, IDLE after the handshake.
- start with op=11 in IDLE -> err=1 for one cycle, busy=0, in_ready=0, no state change.
- Back-to-back: in DONE, out_ready=1 and start=1 with op=OR -> next cycle LOAD with in_ready=1. The second job 10,20,40,80 gives 0xF0, uncontaminated by the first result.
- Assert rst in ACCUM after 2 operands -> outputs read 0 immediately (asynchronously, before the next edge). A following AND job of FF,0F,FF,FF gives 0F.
